cvxif_ooo_copro: RTL and testbench
==================================

Name: cvxif_ooo_copro

Overview:
- Parametrised CV-X-IF coprocessor that tracks up to DEPTH speculative instructions by id. Each entry waits for commit or kill, executes with a configurable latency, and returns results in issue order under result_ready backpressure.
- Supported operations: ADD, ADD3, SUB, NOP, plus a trapping op.
- Sits between the CVA6 CV-X-IF issue/commit/result channels and the core. The compressed and memory channels are tied off in the wrapper.

Parameters:
- XLEN, 64, operand/result width.
- NR_RS, 2, number of source operands (2 or 3).
- ID_WIDTH, 3, width of the instruction id.
- DEPTH, 4, number of in-flight entries (power of two, ≥2).
- LATENCY, 2, execute cycles from commit to result-ready (≥0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  issue request
- issue_ready_o  out  1  issue slot available
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction id
- issue_rs_i  in  NR_RS*XLEN  packed operands, rs1 in LSBs
- issue_rs_valid_i  in  NR_RS  operand valid bits
- issue_accept_o  out  1  instruction accepted (combinational)
- issue_writeback_o  out  1  will write rd (combinational)
- commit_valid_i  in  1  commit event
- commit_id_i  in  ID_WIDTH  committed id
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  ID_WIDTH  id of result
- result_data_o  out  XLEN  result value
- result_rd_o  out  5  destination register (instr[11:7])
- result_we_o  out  1  register write enable
- result_exc_o  out  1  exception flag
- result_exccode_o  out  6  exception code

Behaviour:
- Reset values:
  - All entries FREE; head = tail = count = 0.
  - issue_ready_o = 1; result_valid_o = 0.
  - All result_* outputs = 0 when result_valid_o = 0.
- Decode is combinational, on opcode 7'b1111011. funct3 selects:
  - 000 ADD: rs1+rs2.
  - 001 ADD3: rs1+rs2+rs3; accepted only if NR_RS=3.
  - 010 SUB: rs1-rs2.
  - 100 NOP: accept=1, writeback=0.
  - 111 TRAP: accept=1, writeback=0; result carries exc=1, exccode=2.
- Arithmetic is modulo 2^XLEN; there is no overflow flag.
- Accept also requires issue_rs_valid_i set for every operand the op uses. Any other encoding gives accept=0 and writeback=0.
- Issue handshake fires on issue_valid_i & issue_ready_o.
  - Accepted: allocate the entry at tail, store id, rd, writeback and the precomputed result; state WAIT; tail++.
  - Rejected: handshake completes with no allocation.
- issue_ready_o = (count != DEPTH), computed from registered count. A pop in the same cycle does not free a slot for that cycle's issue.
- Entry states: FREE → WAIT → EXEC → DONE → FREE, plus WAIT → KILLED → FREE.
  - WAIT, commit_valid_i & !kill & id match: go to EXEC with counter = LATENCY. If LATENCY = 0, go directly to DONE.
  - WAIT, commit_valid_i & kill & id match: go to KILLED.
  - EXEC: counter decrements each cycle; at 1, go to DONE.
- Commit matching: a commit/kill applies to the oldest WAIT entry with matching id. If no such entry exists, the event is ignored. Entries in EXEC/DONE are never killed.
- A commit/kill in the same cycle as issue of the same id does not match the new entry; the new entry is visible to commits from the next cycle.
- Results are strictly in issue order, from the head entry only.
  - result_valid_o = head state DONE.
  - result_we_o = stored writeback & result_valid_o.
  - Outputs hold stable while result_valid_o = 1 and result_ready_i = 0.
- Pop rules:
  - DONE head pops on result_valid_o & result_ready_i.
  - KILLED head pops silently, one per cycle, with result_valid_o = 0 that cycle.
- Count updates by +issue_alloc -pop, so a simultaneous alloc and pop leaves count unchanged.
- Head/tail wrap modulo DEPTH.
- Asynchronous reset mid-operation discards all entries with no result emitted.

Decomposition:
- Package cvxif_ooo_pkg holds:
  - entry state enum (FREE/WAIT/EXEC/DONE/KILLED);
  - entry struct {id, rd, we, data, exc, exccode, state, cnt};
  - funct3 constants;
  - OPCODE constant;
  - exccode constant 6'd2.
- One sub-module, cvxif_ooo_decoder: combinational decode plus operand arithmetic, producing accept, writeback, data, exc and exccode.

Test Plan:
- Reset, then issue ADD id=1 with rs1=5, rs2=7 → accept=1, writeback=1. Then commit id=1 → with LATENCY=2, result_valid_o rises 2 cycles after commit with data=12, id=1, we=1.
- Issue SUB id=2 (3-5), then kill id=2 → no result emitted. count returns to 0 one cycle after the KILLED head pops; issue_ready_o=1.
- Fill DEPTH=4 entries (ids 0–3) without commit → issue_ready_o=0 and a 5th issue_valid_i stalls. Commit id 0 → after its result is popped, issue_ready_o returns to 1 the following cycle.
- Issue ids 0, 1; commit id 1 before id 0, so entry 1 reaches DONE first → no result until id 0 completes. Results then appear in the order 0, 1.
- Hold result_ready_i=0 for 5 cycles with result_valid_o=1 → all result_* stable. Raise ready → pop in one cycle and the next result appears next cycle.
- Issue funct3=001 with NR_RS=2 → accept=0, no allocation. Issue TRAP id=3 and commit it → result exc=1, exccode=2, we=0.

Source files
------------

// File: rtl/cvxif_ooo_pkg.sv
`default_nettype none
// ============================================================================
// cvxif_ooo_pkg : shared types and decode constants for cvxif_ooo_copro
// Revision      : 1.0 - initial release
// ============================================================================
package cvxif_ooo_pkg;

    // Entry fields are sized for the largest supported configuration.
    // Narrower instances zero-extend on write and slice on read.
    localparam int ENTRY_XLEN  = 64;
    localparam int ENTRY_ID_W  = 8;
    localparam int ENTRY_CNT_W = 8;

    localparam logic [6:0] OPCODE = 7'b1111011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_ADD3 = 3'b001;
    localparam logic [2:0] F3_SUB  = 3'b010;
    localparam logic [2:0] F3_NOP  = 3'b100;
    localparam logic [2:0] F3_TRAP = 3'b111;

    localparam logic [5:0] EXCCODE_TRAP = 6'd2;

    typedef enum logic [2:0] {
        ST_FREE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_DONE   = 3'd3,
        ST_KILLED = 3'd4
    } entry_state_e;

    typedef struct packed {
        logic [ENTRY_ID_W-1:0]  id;
        logic [4:0]             rd;
        logic                   we;
        logic [ENTRY_XLEN-1:0]  data;
        logic                   exc;
        logic [5:0]             exccode;
        entry_state_e           state;
        logic [ENTRY_CNT_W-1:0] cnt;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/cvxif_ooo_decoder.sv
`default_nettype none
// ============================================================================
// cvxif_ooo_decoder : combinational decode and operand arithmetic
// Revision          : 1.0 - initial release
// ============================================================================
module cvxif_ooo_decoder
    import cvxif_ooo_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NR_RS = 2
) (
    input  logic [31:0]         instr_i,
    input  logic [NR_RS*XLEN-1:0] rs_i,
    input  logic [NR_RS-1:0]    rs_valid_i,
    output logic                accept_o,
    output logic                writeback_o,
    output logic [XLEN-1:0]     data_o,
    output logic                exc_o,
    output logic [5:0]          exccode_o
);

    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rs3;
    logic            rs3_valid;
    logic            unused_instr;

    assign rs1 = rs_i[XLEN-1:0];
    assign rs2 = rs_i[2*XLEN-1:XLEN];

    // A two-operand build has no third operand, so ADD3 can never be accepted.
    if (NR_RS >= 3) begin : g_rs3
        assign rs3       = rs_i[3*XLEN-1:2*XLEN];
        assign rs3_valid = rs_valid_i[2];
    end else begin : g_no_rs3
        assign rs3       = '0;
        assign rs3_valid = 1'b0;
    end

    assign unused_instr = ^{instr_i[31:15], instr_i[11:7]};

    always_comb begin
        accept_o    = 1'b0;
        writeback_o = 1'b0;
        data_o      = '0;
        exc_o       = 1'b0;
        exccode_o   = '0;
        if (instr_i[6:0] == OPCODE) begin
            case (instr_i[14:12])
                F3_ADD: begin
                    if (rs_valid_i[0] && rs_valid_i[1]) begin
                        accept_o    = 1'b1;
                        writeback_o = 1'b1;
                        data_o      = rs1 + rs2;
                    end
                end
                F3_ADD3: begin
                    if (rs_valid_i[0] && rs_valid_i[1] && rs3_valid) begin
                        accept_o    = 1'b1;
                        writeback_o = 1'b1;
                        data_o      = rs1 + rs2 + rs3;
                    end
                end
                F3_SUB: begin
                    if (rs_valid_i[0] && rs_valid_i[1]) begin
                        accept_o    = 1'b1;
                        writeback_o = 1'b1;
                        data_o      = rs1 - rs2;
                    end
                end
                F3_NOP: begin
                    accept_o = 1'b1;
                end
                F3_TRAP: begin
                    accept_o  = 1'b1;
                    exc_o     = 1'b1;
                    exccode_o = EXCCODE_TRAP;
                end
                default: begin
                    accept_o = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cvxif_ooo_copro.sv
`default_nettype none
// ============================================================================
// cvxif_ooo_copro : CV-X-IF coprocessor tracking speculative ops by id,
//                   resolving commit/kill out of order, retiring in order
// Revision        : 1.0 - initial release
// ============================================================================
module cvxif_ooo_copro
    import cvxif_ooo_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NR_RS    = 2,
    parameter int ID_WIDTH = 3,
    parameter int DEPTH    = 4,
    parameter int LATENCY  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [ID_WIDTH-1:0]   issue_id_i,
    input  logic [NR_RS*XLEN-1:0] issue_rs_i,
    input  logic [NR_RS-1:0]      issue_rs_valid_i,
    output logic                  issue_accept_o,
    output logic                  issue_writeback_o,
    input  logic                  commit_valid_i,
    input  logic [ID_WIDTH-1:0]   commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [ID_WIDTH-1:0]   result_id_o,
    output logic [XLEN-1:0]       result_data_o,
    output logic [4:0]            result_rd_o,
    output logic                  result_we_o,
    output logic                  result_exc_o,
    output logic [5:0]            result_exccode_o
);

    localparam int                     PTRW       = $clog2(DEPTH);
    localparam logic [PTRW:0]          COUNT_FULL = (PTRW+1)'(DEPTH);
    localparam logic [ENTRY_CNT_W-1:0] LAT_INIT   = ENTRY_CNT_W'(LATENCY);

    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];
    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [PTRW:0]   count_q, count_d;

    logic            dec_accept;
    logic            dec_writeback;
    logic [XLEN-1:0] dec_data;
    logic            dec_exc;
    logic [5:0]      dec_exccode;

    logic            alloc;
    logic            pop;
    logic            match_found;
    logic [PTRW-1:0] match_idx;
    entry_t          head_entry;
    logic            unused_head_bits;

    cvxif_ooo_decoder #(
        .XLEN  (XLEN),
        .NR_RS (NR_RS)
    ) u_decoder (
        .instr_i     (issue_instr_i),
        .rs_i        (issue_rs_i),
        .rs_valid_i  (issue_rs_valid_i),
        .accept_o    (dec_accept),
        .writeback_o (dec_writeback),
        .data_o      (dec_data),
        .exc_o       (dec_exc),
        .exccode_o   (dec_exccode)
    );

    assign issue_ready_o     = (count_q != COUNT_FULL);
    assign issue_accept_o    = dec_accept;
    assign issue_writeback_o = dec_writeback;
    assign alloc             = issue_valid_i & issue_ready_o & dec_accept;

    assign head_entry     = entries_q[head_q];
    assign result_valid_o = (head_entry.state == ST_DONE);
    assign pop            = (result_valid_o & result_ready_i) | (head_entry.state == ST_KILLED);

    assign result_id_o      = result_valid_o ? head_entry.id[ID_WIDTH-1:0] : '0;
    assign result_data_o    = result_valid_o ? head_entry.data[XLEN-1:0]   : '0;
    assign result_rd_o      = result_valid_o ? head_entry.rd               : '0;
    assign result_we_o      = result_valid_o & head_entry.we;
    assign result_exc_o     = result_valid_o & head_entry.exc;
    assign result_exccode_o = result_valid_o ? head_entry.exccode          : '0;
    assign unused_head_bits = ^{head_entry.id, head_entry.data, head_entry.cnt};

    // Walk from head so the first hit is the oldest WAIT entry with this id.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!match_found
                && entries_q[head_q + PTRW'(k)].state == ST_WAIT
                && entries_q[head_q + PTRW'(k)].id[ID_WIDTH-1:0] == commit_id_i) begin
                match_found = 1'b1;
                match_idx   = head_q + PTRW'(k);
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].state == ST_EXEC) begin
                if (entries_q[i].cnt <= ENTRY_CNT_W'(1)) begin
                    entries_d[i].state = ST_DONE;
                end else begin
                    entries_d[i].cnt = entries_q[i].cnt - ENTRY_CNT_W'(1);
                end
            end
        end

        if (commit_valid_i && match_found) begin
            if (commit_kill_i) begin
                entries_d[match_idx].state = ST_KILLED;
            end else if (LATENCY == 0) begin
                entries_d[match_idx].state = ST_DONE;
            end else begin
                entries_d[match_idx].state = ST_EXEC;
                entries_d[match_idx].cnt   = LAT_INIT;
            end
        end

        if (pop) begin
            entries_d[head_q].state = ST_FREE;
            head_d                  = head_q + PTRW'(1);
        end

        // The tail slot is FREE whenever alloc is possible, so it never
        // collides with the commit or pop updates above.
        if (alloc) begin
            entries_d[tail_q].id      = ENTRY_ID_W'(issue_id_i);
            entries_d[tail_q].rd      = issue_instr_i[11:7];
            entries_d[tail_q].we      = dec_writeback;
            entries_d[tail_q].data    = ENTRY_XLEN'(dec_data);
            entries_d[tail_q].exc     = dec_exc;
            entries_d[tail_q].exccode = dec_exccode;
            entries_d[tail_q].state   = ST_WAIT;
            entries_d[tail_q].cnt     = '0;
            tail_d                    = tail_q + PTRW'(1);
        end

        count_d = count_q + (PTRW+1)'(alloc) - (PTRW+1)'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cvxif_ooo_copro.sv
`default_nettype none
// ============================================================================
// tb_cvxif_ooo_copro : directed self-checking bench for cvxif_ooo_copro
// Revision           : 1.0 - initial release
// ============================================================================
module tb_cvxif_ooo_copro;

    localparam int XLEN     = 64;
    localparam int NR_RS    = 2;
    localparam int ID_WIDTH = 3;
    localparam int DEPTH    = 4;
    localparam int LATENCY  = 2;

    localparam logic [2:0] F_ADD  = 3'b000;
    localparam logic [2:0] F_ADD3 = 3'b001;
    localparam logic [2:0] F_SUB  = 3'b010;
    localparam logic [2:0] F_NOP  = 3'b100;
    localparam logic [2:0] F_TRAP = 3'b111;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  issue_valid_i = 1'b0;
    logic                  issue_ready_o;
    logic [31:0]           issue_instr_i = '0;
    logic [ID_WIDTH-1:0]   issue_id_i = '0;
    logic [NR_RS*XLEN-1:0] issue_rs_i = '0;
    logic [NR_RS-1:0]      issue_rs_valid_i = '0;
    logic                  issue_accept_o;
    logic                  issue_writeback_o;
    logic                  commit_valid_i = 1'b0;
    logic [ID_WIDTH-1:0]   commit_id_i = '0;
    logic                  commit_kill_i = 1'b0;
    logic                  result_valid_o;
    logic                  result_ready_i = 1'b0;
    logic [ID_WIDTH-1:0]   result_id_o;
    logic [XLEN-1:0]       result_data_o;
    logic [4:0]            result_rd_o;
    logic                  result_we_o;
    logic                  result_exc_o;
    logic [5:0]            result_exccode_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    cvxif_ooo_copro #(
        .XLEN(XLEN), .NR_RS(NR_RS), .ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
        .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
        .result_we_o(result_we_o), .result_exc_o(result_exc_o), .result_exccode_o(result_exccode_o)
    );

    function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, 7'b1111011};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_issue(input logic [2:0] f3, input logic [ID_WIDTH-1:0] id,
                             input logic [4:0] rd, input logic [63:0] a,
                             input logic [63:0] b, input logic [1:0] v);
        issue_valid_i    = 1'b1;
        issue_instr_i    = mk_instr(f3, rd);
        issue_id_i       = id;
        issue_rs_i       = {b, a};
        issue_rs_valid_i = v;
        #1;
    endtask

    task automatic clr_issue();
        issue_valid_i    = 1'b0;
        issue_instr_i    = '0;
        issue_rs_valid_i = '0;
    endtask

    task automatic commit_ev(input logic [ID_WIDTH-1:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (issue_ready_o !== 1'b1) $display("FAIL reset_ready: got %0b want 1", issue_ready_o); else n_pass++;
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", result_valid_o); else n_pass++;
        n_checks++;
        if ({result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o, result_exccode_o} !== '0)
            $display("FAIL reset_outputs: id=%0d data=%0h rd=%0d we=%0b exc=%0b code=%0d want all 0",
                     result_id_o, result_data_o, result_rd_o, result_we_o, result_exc_o, result_exccode_o);
        else n_pass++;
    endtask

    task automatic test_add();
        set_issue(F_ADD, 3'd1, 5'd10, 64'd5, 64'd7, 2'b11);
        n_checks++; if ({issue_accept_o, issue_writeback_o} !== 2'b11) $display("FAIL add_decode: got acc/wb=%b want 11", {issue_accept_o, issue_writeback_o}); else n_pass++;
        tick();
        clr_issue();
        commit_ev(3'd1, 1'b0);
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL add_lat0: got valid %0b want 0", result_valid_o); else n_pass++;
        tick();
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL add_lat1: got valid %0b want 0", result_valid_o); else n_pass++;
        tick();
        n_checks++;
        if ({result_valid_o, result_id_o, result_data_o, result_we_o, result_rd_o, result_exc_o} !== {1'b1, 3'd1, 64'd12, 1'b1, 5'd10, 1'b0})
            $display("FAIL add_result: got v=%0b id=%0d data=%0d we=%0b rd=%0d exc=%0b want 1/1/12/1/10/0",
                     result_valid_o, result_id_o, result_data_o, result_we_o, result_rd_o, result_exc_o);
        else n_pass++;
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        n_checks++; if ({result_valid_o, issue_ready_o} !== 2'b01) $display("FAIL add_pop: got valid/ready=%b want 01", {result_valid_o, issue_ready_o}); else n_pass++;
    endtask

    task automatic test_kill();
        set_issue(F_SUB, 3'd2, 5'd11, 64'd3, 64'd5, 2'b11);
        n_checks++; if (issue_accept_o !== 1'b1) $display("FAIL sub_accept: got %0b want 1", issue_accept_o); else n_pass++;
        tick();
        clr_issue();
        commit_ev(3'd2, 1'b1);
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL kill_novalid: got %0b want 0", result_valid_o); else n_pass++;
        tick();
        n_checks++; if ({result_valid_o, issue_ready_o} !== 2'b01) $display("FAIL kill_drained: got valid/ready=%b want 01", {result_valid_o, issue_ready_o}); else n_pass++;
        // queue must be empty: a fresh op retires normally
        set_issue(F_ADD, 3'd2, 5'd3, 64'd1, 64'd1, 2'b11);
        tick();
        clr_issue();
        commit_ev(3'd2, 1'b0);
        repeat (2) tick();
        n_checks++;
        if ({result_valid_o, result_id_o, result_data_o} !== {1'b1, 3'd2, 64'd2})
            $display("FAIL kill_followup: got v=%0b id=%0d data=%0d want 1/2/2", result_valid_o, result_id_o, result_data_o);
        else n_pass++;
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    task automatic test_full();
        int got;
        for (int k = 0; k < DEPTH; k++) begin
            set_issue(F_ADD, ID_WIDTH'(k), 5'(k + 1), 64'(k), 64'd10, 2'b11);
            n_checks++; if ({issue_ready_o, issue_accept_o} !== 2'b11) $display("FAIL fill_%0d: got ready/acc=%b want 11", k, {issue_ready_o, issue_accept_o}); else n_pass++;
            tick();
            clr_issue();
        end
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL full_ready: got %0b want 0", issue_ready_o); else n_pass++;
        set_issue(F_ADD, 3'd4, 5'd20, 64'd1, 64'd1, 2'b11);
        repeat (2) tick();
        n_checks++; if (issue_ready_o !== 1'b0) $display("FAIL full_stall: got %0b want 0", issue_ready_o); else n_pass++;
        clr_issue();
        commit_ev(3'd0, 1'b0);
        repeat (2) tick();
        n_checks++;
        if ({result_valid_o, result_id_o, result_data_o, issue_ready_o} !== {1'b1, 3'd0, 64'd10, 1'b0})
            $display("FAIL full_head: got v=%0b id=%0d data=%0d ready=%0b want 1/0/10/0",
                     result_valid_o, result_id_o, result_data_o, issue_ready_o);
        else n_pass++;
        result_ready_i = 1'b1;
        tick();
        n_checks++; if (issue_ready_o !== 1'b1) $display("FAIL full_reopen: got %0b want 1", issue_ready_o); else n_pass++;
        commit_ev(3'd1, 1'b0);
        commit_ev(3'd2, 1'b0);
        commit_ev(3'd3, 1'b0);
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (result_valid_o) begin
                n_checks++;
                if ({result_id_o, result_data_o} !== {3'(got + 1), 64'(got + 11)})
                    $display("FAIL drain_%0d: got id=%0d data=%0d want id=%0d data=%0d",
                             got, result_id_o, result_data_o, got + 1, got + 11);
                else n_pass++;
                got++;
            end
            tick();
        end
        result_ready_i = 1'b0;
        n_checks++; if (got !== 3) $display("FAIL drain_count: got %0d results want 3", got); else n_pass++;
    endtask

    task automatic test_out_of_order();
        set_issue(F_ADD, 3'd0, 5'd5, 64'd100, 64'd1, 2'b11);
        tick();
        set_issue(F_ADD, 3'd1, 5'd6, 64'd200, 64'd2, 2'b11);
        tick();
        clr_issue();
        commit_ev(3'd1, 1'b0);
        commit_ev(3'd0, 1'b0);
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL ooo_early0: got %0b want 0", result_valid_o); else n_pass++;
        tick();
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL ooo_blocked: got %0b want 0 (younger done first)", result_valid_o); else n_pass++;
        tick();
        n_checks++;
        if ({result_valid_o, result_id_o, result_data_o} !== {1'b1, 3'd0, 64'd101})
            $display("FAIL ooo_first: got v=%0b id=%0d data=%0d want 1/0/101", result_valid_o, result_id_o, result_data_o);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o} !== {1'b1, 3'd0, 64'd101, 5'd5, 1'b1})
                $display("FAIL hold_%0d: got v=%0b id=%0d data=%0d rd=%0d we=%0b want 1/0/101/5/1",
                         c, result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o);
            else n_pass++;
        end
        result_ready_i = 1'b1;
        tick();
        n_checks++;
        if ({result_valid_o, result_id_o, result_data_o, result_rd_o} !== {1'b1, 3'd1, 64'd202, 5'd6})
            $display("FAIL bp_next: got v=%0b id=%0d data=%0d rd=%0d want 1/1/202/6", result_valid_o, result_id_o, result_data_o, result_rd_o);
        else n_pass++;
        tick();
        result_ready_i = 1'b0;
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL bp_empty: got %0b want 0", result_valid_o); else n_pass++;
    endtask

    task automatic test_reject_and_trap();
        set_issue(F_ADD3, 3'd3, 5'd7, 64'd1, 64'd2, 2'b11);
        n_checks++; if ({issue_accept_o, issue_writeback_o} !== 2'b00) $display("FAIL add3_reject: got acc/wb=%b want 00", {issue_accept_o, issue_writeback_o}); else n_pass++;
        tick();
        set_issue(F_ADD, 3'd3, 5'd7, 64'd1, 64'd2, 2'b01);
        n_checks++; if ({issue_accept_o, issue_writeback_o} !== 2'b00) $display("FAIL rs_missing: got acc/wb=%b want 00", {issue_accept_o, issue_writeback_o}); else n_pass++;
        tick();
        set_issue(F_ADD, 3'd3, 5'd7, 64'd1, 64'd2, 2'b11);
        issue_instr_i = issue_instr_i ^ 32'h1;
        #1;
        n_checks++; if ({issue_accept_o, issue_writeback_o} !== 2'b00) $display("FAIL bad_opcode: got acc/wb=%b want 00", {issue_accept_o, issue_writeback_o}); else n_pass++;
        tick();
        set_issue(F_NOP, 3'd6, 5'd1, 64'd0, 64'd0, 2'b00);
        n_checks++; if ({issue_accept_o, issue_writeback_o} !== 2'b10) $display("FAIL nop_decode: got acc/wb=%b want 10", {issue_accept_o, issue_writeback_o}); else n_pass++;
        tick();
        set_issue(F_TRAP, 3'd3, 5'd9, 64'd0, 64'd0, 2'b00);
        n_checks++; if ({issue_accept_o, issue_writeback_o} !== 2'b10) $display("FAIL trap_decode: got acc/wb=%b want 10", {issue_accept_o, issue_writeback_o}); else n_pass++;
        tick();
        clr_issue();
        commit_ev(3'd3, 1'b0);
        commit_ev(3'd6, 1'b0);
        tick();
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL nop_wait: got %0b want 0", result_valid_o); else n_pass++;
        tick();
        n_checks++;
        if ({result_valid_o, result_id_o, result_we_o, result_exc_o} !== {1'b1, 3'd6, 1'b0, 1'b0})
            $display("FAIL nop_result: got v=%0b id=%0d we=%0b exc=%0b want 1/6/0/0", result_valid_o, result_id_o, result_we_o, result_exc_o);
        else n_pass++;
        result_ready_i = 1'b1;
        tick();
        n_checks++;
        if ({result_valid_o, result_id_o, result_we_o, result_exc_o, result_exccode_o, result_rd_o} !== {1'b1, 3'd3, 1'b0, 1'b1, 6'd2, 5'd9})
            $display("FAIL trap_result: got v=%0b id=%0d we=%0b exc=%0b code=%0d rd=%0d want 1/3/0/1/2/9",
                     result_valid_o, result_id_o, result_we_o, result_exc_o, result_exccode_o, result_rd_o);
        else n_pass++;
        tick();
        result_ready_i = 1'b0;
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL trap_empty: got %0b want 0", result_valid_o); else n_pass++;
    endtask

    task automatic test_sub_wrap();
        set_issue(F_SUB, 3'd5, 5'd12, 64'd3, 64'd5, 2'b11);
        tick();
        clr_issue();
        commit_ev(3'd4, 1'b0);
        repeat (3) tick();
        n_checks++; if (result_valid_o !== 1'b0) $display("FAIL stray_commit: got valid %0b want 0", result_valid_o); else n_pass++;
        commit_ev(3'd5, 1'b0);
        repeat (2) tick();
        n_checks++;
        if ({result_valid_o, result_id_o, result_data_o} !== {1'b1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFE})
            $display("FAIL sub_wrap: got v=%0b id=%0d data=%0h want 1/5/fffffffffffffffe", result_valid_o, result_id_o, result_data_o);
        else n_pass++;
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        set_issue(F_ADD, 3'd1, 5'd4, 64'd1, 64'd2, 2'b11);
        tick();
        clr_issue();
        commit_ev(3'd1, 1'b0);
        repeat (2) tick();
        n_checks++; if (result_valid_o !== 1'b1) $display("FAIL pre_reset_valid: got %0b want 1", result_valid_o); else n_pass++;
        #1 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({result_valid_o, issue_ready_o, result_data_o} !== {1'b0, 1'b1, 64'd0})
            $display("FAIL async_reset: got v=%0b ready=%0b data=%0d want 0/1/0", result_valid_o, issue_ready_o, result_data_o);
        else n_pass++;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();
        n_checks++; if ({result_valid_o, issue_ready_o} !== 2'b01) $display("FAIL post_reset: got valid/ready=%b want 01", {result_valid_o, issue_ready_o}); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        rst_ni = 1'b1;
        tick();
        test_add();
        test_kill();
        test_full();
        test_out_of_order();
        test_backpressure();
        test_reject_and_trap();
        test_sub_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
